adc_spi_regfile_slave: RTL and testbench
========================================

Name: adc_spi_regfile_slave

Overview:
Parametrised SPI-mode-0 register-file slave for the SAR ADC. It succeeds the fixed 12-bit, 4-register SPI slave with:
- configurable data width, address width and channel count;
- per-channel ADC sample registers with ready/overflow flags;
- an auto-increment burst mode within one CS assertion.

SCK, CS and MOSI are oversampled in the system clock domain. The block sits between the external SPI pins and the SAR conversion core.

Parameters:
DATA_W, 12, register and data-field width; must satisfy DATA_W >= 2*NUM_CH+1
ADDR_W, 3, address field width; must satisfy 4+NUM_CH <= 2**ADDR_W
NUM_CH, 4, number of ADC channel data registers

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
sck  in  1  SPI clock, asynchronous, CPOL=0
cs  in  1  SPI chip select, active low, asynchronous
mosi  in  1  SPI data in, asynchronous
miso  out  1  SPI data out; 0 outside a read data phase
adc_data  in  NUM_CH*DATA_W  channel n sample at [n*DATA_W +: DATA_W]
adc_valid  in  NUM_CH  one-clk strobe per channel; loads the matching adc_data slice
ctrl_out  out  DATA_W  CTRL register contents
offset_out  out  DATA_W  OFFSET register contents

Behaviour:
- Synchronisation and timing
  - sck, cs and mosi pass through 2-FF synchronisers; SCK edges are detected on the synchronised signal.
  - Required SCK high and low times: each >= 4 clk periods.
- Frame format, MSB first: CMD[1:0], ADDR[ADDR_W-1:0], DATA[DATA_W-1:0]; FRAME_W = 2+ADDR_W+DATA_W.
  - CMD: 00 READ, 01 WRITE, 10 SET (reg |= data), 11 CLEAR (reg &= ~data).
- Address map
  - 0 CTRL: RW, reset 0. Bit 0 = AUTO_INC; other bits are general purpose.
  - 1 STATUS: RO. Value = {1'b1, zeros, ovf[NUM_CH-1:0], rdy[NUM_CH-1:0]}; reset value 1<<(DATA_W-1), i.e. 0x800 at defaults.
  - 2 OFFSET: RW, reset 0.
  - 3: reserved; reads 0, writes ignored.
  - 4..4+NUM_CH-1 CH_DATA[n]: RO, reset 0.
  - Any other address: reads 0, writes ignored.
  - WRITE/SET/CLEAR to any RO or reserved address has no effect.
- MOSI and MISO edges
  - MOSI is captured on the detected SCK rising edge.
  - MISO updates within 3 clk of the detected SCK falling edge.
- Read data path
  - READ: the addressed register is snapshotted into the shift register on the SCK falling edge that ends the last ADDR bit.
  - DATA MSB is driven from that edge; each following falling edge shifts out the next bit.
  - The master samples each bit on the next falling edge.
- Commit timing
  - WRITE/SET/CLEAR commits 1 clk after the rising edge capturing the last DATA bit.
  - A READ of CH_DATA[n] clears rdy[n] and ovf[n] at the same point.
- FSM states: IDLE, HEADER (2+ADDR_W bits), DATA (DATA_W bits), DONE.
  - IDLE -> HEADER on CS falling edge; the bit counter is cleared and AUTO_INC is latched for the whole CS assertion.
  - HEADER -> DATA after the last ADDR bit.
  - DATA -> DONE after the last DATA bit, with commit.
  - DONE with AUTO_INC=0 -> HEADER: the next full frame in the same CS is accepted (back-to-back operation).
  - DONE with AUTO_INC=1 -> DATA: burst continuation. The word applies the same CMD to ADDR+1 mod 2**ADDR_W. For READ, the next register is snapshotted on the falling edge ending the previous word.
  - CS rising in any state -> IDLE. A partial frame or word is discarded with no commit and no flag clear; miso goes to 0.
  - SCK edges while CS is high are ignored.
- Channel inputs
  - adc_valid[n] loads CH_DATA[n] and sets rdy[n]. If rdy[n] was already 1, ovf[n] is also set.
  - If adc_valid[n] arrives in the same clk as a read-clear of channel n: rdy[n]=1, ovf[n]=0 and the new data is kept.
  - A READ snapshot is unaffected by later adc_valid pulses within the same word.
- reset: asynchronously returns every register, flag, counter and the FSM to reset values; miso=0, ctrl_out=0, offset_out=0. A reset mid-frame aborts that frame.

Test Plan:
- Reset, then READ STATUS -> 0x800; READ CTRL, OFFSET and CH_DATA[0..3] -> 0x000 each.
- WRITE CTRL 0xA5A, READ -> 0xA5A and ctrl_out=0xA5A. WRITE 0xC33, SET 0x0F0 -> 0xCF3. CLEAR 0xC0C -> 0x0F3. WRITE STATUS 0xBAD -> STATUS still 0x800.
- adc_valid[2] with data 0x3C1:
  - READ STATUS -> 0x804; READ CH_DATA[2] -> 0x3C1; READ STATUS again -> 0x800.
  - Two valids without a read -> STATUS 0x844.
- AUTO_INC=0: one CS carries WRITE CTRL 0xCDE then READ CTRL -> 0xCDE.
- AUTO_INC=1 (CTRL=0x001): burst WRITE header at addr 2 with 0x111 plus 1 continuation word -> OFFSET=0x111, reserved addr unchanged. Burst READ from addr 4 for 4 words -> CH_DATA[0..3] in order, and all rdy bits cleared.
- Abort cases:
  - WRITE CTRL 0x123, then a WRITE 0xFFF cut after 10 bits by CS high -> CTRL=0x123.
  - 20 SCK toggles with CS high, then READ STATUS -> 0x800.
  - reset asserted mid-frame -> all registers at reset values.

Source files
------------

// File: rtl/adc_spi_regfile_slave_if.sv
// SPI pin bundle for the ADC register-file slave.
//   sck  : SPI clock (CPOL=0), driven by the master
//   cs   : chip select, active low, driven by the master
//   mosi : serial data towards the slave
//   miso : serial data towards the master
interface adc_spi_regfile_slave_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;

    modport master (
        output sck,
        output cs,
        output mosi,
        input  miso
    );

    modport slave (
        input  sck,
        input  cs,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/adc_spi_regfile_slave.sv
// SPI mode-0 register-file slave for the SAR ADC.
// SCK/CS/MOSI are oversampled in the clk domain. Frame, MSB first:
// CMD[1:0] (00 read, 01 write, 10 set, 11 clear), ADDR[ADDR_W-1:0], DATA[DATA_W-1:0].
// Address map: 0 CTRL (bit 0 = AUTO_INC), 1 STATUS, 2 OFFSET, 3 reserved,
// 4..4+NUM_CH-1 per-channel sample registers.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   spi        : SPI pins (sck, cs, mosi in; miso out)
//   adc_data   : channel n sample at [n*DATA_W +: DATA_W]
//   adc_valid  : per-channel one-clk load strobe
//   ctrl_out   : CTRL register contents
//   offset_out : OFFSET register contents
module adc_spi_regfile_slave #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    adc_spi_regfile_slave_if.slave   spi,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic [NUM_CH-1:0]        adc_valid,
    output logic [DATA_W-1:0]        ctrl_out,
    output logic [DATA_W-1:0]        offset_out
);

    localparam int unsigned HDR_W   = 2 + ADDR_W;
    localparam int unsigned FRAME_W = HDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] CmdRead  = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdSet   = 2'b10;
    localparam logic [1:0] CmdClear = 2'b11;

    localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrOffset = ADDR_W'(2);

    typedef enum logic [1:0] {StIdle, StHeader, StData, StDone} state_e;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [2:0] sck_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       cs_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            cs_prev_q   <= 1'b1;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi.sck};
            cs_sync_q   <= {cs_sync_q[0], spi.cs};
            cs_prev_q   <= cs_sync_q[1];
            mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
        end
    end

    logic sck_rise, sck_fall, cs_n, cs_fall, mosi_s;
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_n     = cs_sync_q[1];
    assign cs_fall  = ~cs_sync_q[1] & cs_prev_q;
    assign mosi_s   = mosi_sync_q[1];

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] offset_q;
    logic [DATA_W-1:0] ch_data_q [NUM_CH];
    logic [NUM_CH-1:0] rdy_q;
    logic [NUM_CH-1:0] ovf_q;

    // ------------------------------------------------------------------
    // Frame FSM state
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [HDR_W-2:0]  hdr_q;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_shift_q;
    logic              rd_active_q;
    logic              load_pend_q;  // first DATA falling edge still owes the read snapshot
    logic              auto_inc_q;
    logic              commit_q;

    logic [HDR_W-1:0]  hdr_full;
    assign hdr_full = {hdr_q, mosi_s};

    // In DONE the next falling edge opens the following burst word, so the
    // snapshot must come from the next address.
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = (state_q == StDone) ? addr_q + ADDR_W'(1) : addr_q;

    logic [DATA_W-1:0] status_val;
    always_comb begin
        status_val                   = '0;
        status_val[DATA_W-1]         = 1'b1;
        status_val[2*NUM_CH-1:0]     = {ovf_q, rdy_q};
    end

    logic [DATA_W-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (rd_addr == AddrCtrl) begin
            rd_val = ctrl_q;
        end else if (rd_addr == AddrStatus) begin
            rd_val = status_val;
        end else if (rd_addr == AddrOffset) begin
            rd_val = offset_q;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (rd_addr == ADDR_W'(4 + n)) begin
                    rd_val = ch_data_q[n];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            hdr_q       <= '0;
            cmd_q       <= CmdRead;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_shift_q  <= '0;
            rd_active_q <= 1'b0;
            load_pend_q <= 1'b0;
            auto_inc_q  <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (cs_n) begin
                // CS high aborts whatever is in flight; SCK is ignored.
                state_q     <= StIdle;
                rd_active_q <= 1'b0;
                load_pend_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q    <= StHeader;
                            bit_cnt_q  <= '0;
                            auto_inc_q <= ctrl_q[0];
                        end
                    end
                    StHeader: begin
                        if (sck_rise) begin
                            hdr_q <= hdr_full[HDR_W-2:0];
                            if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
                                cmd_q       <= hdr_full[HDR_W-1 -: 2];
                                addr_q      <= hdr_full[ADDR_W-1:0];
                                state_q     <= StData;
                                bit_cnt_q   <= '0;
                                load_pend_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    StData: begin
                        if (sck_rise) begin
                            wdata_q <= {wdata_q[DATA_W-2:0], mosi_s};
                            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                state_q   <= StDone;
                                bit_cnt_q <= '0;
                                commit_q  <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (sck_fall) begin
                            if (load_pend_q) begin
                                load_pend_q <= 1'b0;
                                rd_shift_q  <= rd_val;
                                rd_active_q <= (cmd_q == CmdRead);
                            end else begin
                                rd_shift_q <= rd_shift_q << 1;
                            end
                        end
                    end
                    StDone: begin
                        if (sck_fall) begin
                            bit_cnt_q <= '0;
                            if (auto_inc_q) begin
                                state_q     <= StData;
                                addr_q      <= addr_q + ADDR_W'(1);
                                rd_shift_q  <= rd_val;
                                rd_active_q <= (cmd_q == CmdRead);
                            end else begin
                                state_q     <= StHeader;
                                rd_active_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign spi.miso = rd_active_q & rd_shift_q[DATA_W-1];

    // ------------------------------------------------------------------
    // Commit of write/set/clear and read-clear of channel flags
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] wr_cur;
    logic [DATA_W-1:0] wr_new;
    always_comb begin
        wr_cur = (addr_q == AddrCtrl) ? ctrl_q : offset_q;
        unique case (cmd_q)
            CmdWrite: wr_new = wdata_q;
            CmdSet:   wr_new = wr_cur | wdata_q;
            CmdClear: wr_new = wr_cur & ~wdata_q;
            default:  wr_new = wr_cur;
        endcase
    end

    logic [NUM_CH-1:0] rd_clr;
    always_comb begin
        rd_clr = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            rd_clr[n] = commit_q && (cmd_q == CmdRead) && (addr_q == ADDR_W'(4 + n));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            offset_q <= '0;
        end else if (commit_q && (cmd_q != CmdRead)) begin
            if (addr_q == AddrCtrl) begin
                ctrl_q <= wr_new;
            end else if (addr_q == AddrOffset) begin
                offset_q <= wr_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q <= '0;
            ovf_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                ch_data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (adc_valid[n]) begin
                    // A coincident read-clear wins over the overflow, not over ready.
                    ch_data_q[n] <= adc_data[n*DATA_W +: DATA_W];
                    rdy_q[n]     <= 1'b1;
                    ovf_q[n]     <= rd_clr[n] ? 1'b0 : (ovf_q[n] | rdy_q[n]);
                end else if (rd_clr[n]) begin
                    rdy_q[n] <= 1'b0;
                    ovf_q[n] <= 1'b0;
                end
            end
        end
    end

    assign ctrl_out   = ctrl_q;
    assign offset_out = offset_q;

endmodule

// File: tb/tb_adc_spi_regfile_slave.sv
// Directed bench for adc_spi_regfile_slave: table of single-frame transactions
// followed by hand-written multi-frame, burst, ADC and abort sequences.
module tb_adc_spi_regfile_slave;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 3;
    localparam int NUM_CH = 4;
    localparam int HDR_W  = 2 + ADDR_W;
    localparam int HALF   = 6;   // SCK half period in clk cycles

    logic                     clk;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] adc_data;
    logic [NUM_CH-1:0]        adc_valid;
    logic [DATA_W-1:0]        ctrl_out;
    logic [DATA_W-1:0]        offset_out;

    adc_spi_regfile_slave_if spi ();

    adc_spi_regfile_slave #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi.slave),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .ctrl_out   (ctrl_out),
        .offset_out (offset_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_ctrl;
        logic [DATA_W-1:0] exp_off;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] cmd, input int addr, input int wd,
                                input int exp_rd, input int exp_ctrl, input int exp_off);
        vec_t v;
        v.cmd      = cmd;
        v.addr     = ADDR_W'(addr);
        v.wdata    = DATA_W'(wd);
        v.exp_rd   = DATA_W'(exp_rd);
        v.exp_ctrl = DATA_W'(exp_ctrl);
        v.exp_off  = DATA_W'(exp_off);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period; miso is sampled right as SCK falls.
    task automatic sck_bit(input logic b, output logic s);
        spi.mosi = b;
        wait_clk(HALF);
        spi.sck = 1'b1;
        wait_clk(HALF);
        s = spi.miso;
        spi.sck = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rd);
        logic s;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            sck_bit(wd[i], s);
            rd[i] = s;
        end
    endtask

    task automatic send_frame(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rd);
        logic [HDR_W-1:0] h;
        logic s;
        h = {cmd, addr};
        for (int i = HDR_W - 1; i >= 0; i--) begin
            sck_bit(h[i], s);
        end
        send_word(wd, rd);
    endtask

    task automatic cs_low();
        spi.cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi.cs = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic txn(input logic [1:0] cmd, input int addr, input int wd,
                       output logic [DATA_W-1:0] rd);
        cs_low();
        send_frame(cmd, ADDR_W'(addr), DATA_W'(wd), rd);
        cs_high();
    endtask

    task automatic read_chk(input string name, input int addr, input int exp);
        logic [DATA_W-1:0] rd;
        txn(2'b00, addr, 0, rd);
        check(name, rd, DATA_W'(exp));
    endtask

    task automatic pulse_valid(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d);
        adc_data  = d;
        adc_valid = v;
        wait_clk(1);
        adc_valid = '0;
        wait_clk(2);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic              s;

        reset     = 1'b1;
        spi.sck   = 1'b0;
        spi.cs    = 1'b1;
        spi.mosi  = 1'b0;
        adc_data  = '0;
        adc_valid = '0;
        wait_clk(5);
        check("reset_ctrl_out", ctrl_out, 12'h000);
        check("reset_offset_out", offset_out, 12'h000);
        check("reset_miso", {11'b0, spi.miso}, 12'h000);
        reset = 1'b0;
        wait_clk(5);

        // cmd, addr, wdata, expected read, expected ctrl_out, expected offset_out
        add(2'b00, 1, 0,      12'h800, 12'h000, 12'h000);
        add(2'b00, 0, 0,      12'h000, 12'h000, 12'h000);
        add(2'b00, 2, 0,      12'h000, 12'h000, 12'h000);
        add(2'b00, 4, 0,      12'h000, 12'h000, 12'h000);
        add(2'b00, 5, 0,      12'h000, 12'h000, 12'h000);
        add(2'b00, 6, 0,      12'h000, 12'h000, 12'h000);
        add(2'b00, 7, 0,      12'h000, 12'h000, 12'h000);
        add(2'b01, 0, 12'hA5A, 0,      12'hA5A, 12'h000);
        add(2'b00, 0, 0,      12'hA5A, 12'hA5A, 12'h000);
        add(2'b01, 0, 12'hC33, 0,      12'hC33, 12'h000);
        add(2'b10, 0, 12'h0F0, 0,      12'hCF3, 12'h000);
        add(2'b00, 0, 0,      12'hCF3, 12'hCF3, 12'h000);
        add(2'b11, 0, 12'hC0C, 0,      12'h0F3, 12'h000);
        add(2'b00, 0, 0,      12'h0F3, 12'h0F3, 12'h000);
        add(2'b01, 1, 12'hBAD, 0,      12'h0F3, 12'h000);
        add(2'b00, 1, 0,      12'h800, 12'h0F3, 12'h000);
        add(2'b01, 3, 12'h123, 0,      12'h0F3, 12'h000);
        add(2'b00, 3, 0,      12'h000, 12'h0F3, 12'h000);
        add(2'b01, 2, 12'h5A5, 0,      12'h0F3, 12'h5A5);
        add(2'b00, 2, 0,      12'h5A5, 12'h0F3, 12'h5A5);
        add(2'b10, 4, 12'hFFF, 0,      12'h0F3, 12'h5A5);
        add(2'b00, 4, 0,      12'h000, 12'h0F3, 12'h5A5);
        add(2'b01, 0, 12'h000, 0,      12'h000, 12'h5A5);
        add(2'b01, 2, 12'h000, 0,      12'h000, 12'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].cmd, int'(vecs[i].addr), int'(vecs[i].wdata), rd);
            if (vecs[i].cmd == 2'b00) begin
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
            check($sformatf("vec%0d_off", i), offset_out, vecs[i].exp_off);
        end

        // ADC sample on channel 2, read-clear, then overflow
        pulse_valid(4'b0100, {12'h000, 12'h3C1, 12'h000, 12'h000});
        read_chk("adc_status_rdy", 1, 12'h804);
        read_chk("adc_ch2_data", 6, 12'h3C1);
        read_chk("adc_status_cleared", 1, 12'h800);
        pulse_valid(4'b0100, {12'h000, 12'h3C2, 12'h000, 12'h000});
        pulse_valid(4'b0100, {12'h000, 12'h3C3, 12'h000, 12'h000});
        read_chk("adc_status_ovf", 1, 12'h844);
        read_chk("adc_ch2_latest", 6, 12'h3C3);
        read_chk("adc_status_ovf_cleared", 1, 12'h800);

        // Back-to-back frames in one CS with AUTO_INC=0
        cs_low();
        send_frame(2'b01, 3'd0, 12'hCDE, rd);
        send_frame(2'b00, 3'd0, 12'h000, rd);
        cs_high();
        check("b2b_read_ctrl", rd, 12'hCDE);
        check("b2b_ctrl_out", ctrl_out, 12'hCDE);

        // Burst write: OFFSET then the reserved address
        txn(2'b01, 0, 12'h001, rd);
        cs_low();
        send_frame(2'b01, 3'd2, 12'h111, rd);
        send_word(12'h222, rd);
        cs_high();
        check("burst_wr_offset_out", offset_out, 12'h111);
        read_chk("burst_wr_offset", 2, 12'h111);
        read_chk("burst_wr_reserved", 3, 12'h000);

        // Burst read of all channels
        pulse_valid(4'b1111, {12'h404, 12'h303, 12'h202, 12'h101});
        read_chk("burst_status_pre", 1, 12'h80F);
        cs_low();
        send_frame(2'b00, 3'd4, 12'h000, rd);
        check("burst_rd_ch0", rd, 12'h101);
        send_word(12'h000, rd);
        check("burst_rd_ch1", rd, 12'h202);
        send_word(12'h000, rd);
        check("burst_rd_ch2", rd, 12'h303);
        send_word(12'h000, rd);
        check("burst_rd_ch3", rd, 12'h404);
        cs_high();
        read_chk("burst_status_post", 1, 12'h800);

        // Partial frame cut by CS high
        txn(2'b01, 0, 12'h123, rd);
        cs_low();
        begin
            logic [HDR_W+DATA_W-1:0] f;
            f = {2'b01, 3'd0, 12'hFFF};
            for (int i = HDR_W + DATA_W - 1; i >= HDR_W + DATA_W - 10; i--) begin
                sck_bit(f[i], s);
            end
        end
        cs_high();
        check("abort_ctrl_out", ctrl_out, 12'h123);
        read_chk("abort_ctrl", 0, 12'h123);

        // SCK toggles with CS high are ignored
        spi.mosi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spi.sck = ~spi.sck;
            wait_clk(HALF);
        end
        spi.sck = 1'b0;
        wait_clk(HALF);
        read_chk("cs_high_sck_status", 1, 12'h800);
        read_chk("cs_high_sck_ctrl", 0, 12'h123);

        // Reset mid-frame
        txn(2'b01, 2, 12'h0AA, rd);
        pulse_valid(4'b0010, {12'h000, 12'h000, 12'h055, 12'h000});
        cs_low();
        for (int i = 0; i < 8; i++) begin
            sck_bit(1'b1, s);
        end
        reset = 1'b1;
        wait_clk(3);
        spi.cs = 1'b1;
        wait_clk(3);
        check("midrst_ctrl_out", ctrl_out, 12'h000);
        check("midrst_offset_out", offset_out, 12'h000);
        check("midrst_miso", {11'b0, spi.miso}, 12'h000);
        reset = 1'b0;
        wait_clk(5);
        read_chk("midrst_status", 1, 12'h800);
        read_chk("midrst_ctrl", 0, 12'h000);
        read_chk("midrst_offset", 2, 12'h000);
        read_chk("midrst_ch1", 5, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
